// File: rtl/shift_rotate_if.sv
// Request/response bundle between the ALU datapath and the shift/rotate unit.
// The master drives the request; the slave (the unit) returns result and status.
interface shift_rotate_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             ready;
    logic             cout;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  result, done, busy, ready, cout, zero
    );

    modport slave (
        input  start, op, a, b,
        output result, done, busy, ready, cout, zero
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit: SHR/SHRA/SHL/ROR/ROL, up to STEP bits per clock,
// start/done handshake with registered result, carry-out and zero flags.
module shift_rotate_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STEP    = 1
) (
    input  logic          clock,
    input  logic          clear,
    shift_rotate_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [2:0] OpShr  = 3'b000;
    localparam logic [2:0] OpShra = 3'b001;
    localparam logic [2:0] OpShl  = 3'b010;
    localparam logic [2:0] OpRor  = 3'b011;
    localparam logic [2:0] OpRol  = 3'b100;

    localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [2:0]         opc_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q, cout_d;
    logic               zero_q;
    logic               done_q, busy_q, ready_q;

    logic [SHAMT_W-1:0] step_amt;
    logic [SHAMT_W-1:0] shamt_in;
    logic               op_valid;
    logic               accept;
    logic               unused_b;

    assign shamt_in = bus.b[SHAMT_W-1:0];
    assign unused_b = ^bus.b[WIDTH-1:SHAMT_W];
    assign op_valid = (bus.op <= OpRol);
    assign accept   = ready_q & bus.start;

    // One step = up to STEP single-bit moves; cout tracks the last bit moved.
    always_comb begin
        step_amt = (rem_q < StepAmt) ? rem_q : StepAmt;
        rem_d    = rem_q - step_amt;
        acc_d    = acc_q;
        cout_d   = 1'b0;
        for (int i = 0; i < int'(STEP); i++) begin
            if (SHAMT_W'(i) < step_amt) begin
                case (opc_q)
                    OpShr: begin
                        cout_d = acc_d[0];
                        acc_d  = {1'b0, acc_d[WIDTH-1:1]};
                    end
                    OpShra: begin
                        cout_d = acc_d[0];
                        acc_d  = {acc_d[WIDTH-1], acc_d[WIDTH-1:1]};
                    end
                    OpShl: begin
                        cout_d = acc_d[WIDTH-1];
                        acc_d  = {acc_d[WIDTH-2:0], 1'b0};
                    end
                    OpRor: begin
                        cout_d = acc_d[0];
                        acc_d  = {acc_d[0], acc_d[WIDTH-1:1]};
                    end
                    OpRol: begin
                        cout_d = acc_d[WIDTH-1];
                        acc_d  = {acc_d[WIDTH-2:0], acc_d[WIDTH-1]};
                    end
                    default: begin
                        cout_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            rem_q    <= '0;
            opc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        acc_q <= bus.a;
                        opc_q <= bus.op;
                        rem_q <= shamt_in;
                        if (shamt_in == '0 || !op_valid) begin
                            // Nothing to shift: pass a straight through.
                            state_q  <= StDone;
                            result_q <= bus.a;
                            cout_q   <= 1'b0;
                            zero_q   <= (bus.a == '0);
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                        end else begin
                            state_q <= StShift;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                StShift: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        state_q  <= StDone;
                        result_q <= acc_d;
                        cout_q   <= cout_d;
                        zero_q   <= (acc_d == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;
endmodule
